// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - stream-driven preload engine for imem, dmem and register file
// Holds the core in reset until an END record is accepted.
module boot_loader #(
    parameter int ADDR_W     = 30,
    parameter bit PROTECT_R0 = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_in_valid,
    input  logic [31:0]       i_in_data,
    output logic              o_in_ready,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_dmem_we,
    output logic [ADDR_W-1:0] o_dmem_addr,
    output logic [31:0]       o_dmem_wdata,
    output logic              o_rf_we,
    output logic [4:0]        o_rf_waddr,
    output logic [31:0]       o_rf_wdata,
    output logic              o_core_reset,
    output logic              o_error
);

    typedef enum logic [2:0] {
        S_HEADER,
        S_ADDR,
        S_DATA,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [1:0] T_IMEM = 2'b00;
    localparam logic [1:0] T_DMEM = 2'b01;
    localparam logic [1:0] T_RF   = 2'b10;
    localparam logic [1:0] T_END  = 2'b11;

    state_t            r_state, w_next_state;
    logic [1:0]        r_target, w_target;
    logic [13:0]       r_count, w_count;
    logic [ADDR_W-1:0] r_mptr, w_mptr;
    // bit 5 marks a register pointer that has run past r31
    logic [5:0]        r_rptr, w_rptr;
    logic              w_accept;
    logic              w_imem_we, w_dmem_we, w_rf_we;

    always_comb begin
        w_next_state = r_state;
        w_target     = r_target;
        w_count      = r_count;
        w_mptr       = r_mptr;
        w_rptr       = r_rptr;
        w_imem_we    = 1'b0;
        w_dmem_we    = 1'b0;
        w_rf_we      = 1'b0;
        w_accept     = i_in_valid && o_in_ready;
        case (r_state)
            S_HEADER: begin
                if (w_accept) begin
                    w_target = i_in_data[31:30];
                    w_count  = i_in_data[29:16];
                    if (i_in_data[31:30] == T_END) begin
                        w_next_state = S_DONE;
                    end else if (|i_in_data[15:0]) begin
                        w_next_state = S_ERROR;
                    end else begin
                        w_next_state = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (w_accept) begin
                    if (r_target != T_RF && |i_in_data[1:0]) begin
                        w_next_state = S_ERROR;
                    end else begin
                        w_mptr       = i_in_data[ADDR_W+1:2];
                        w_rptr       = {1'b0, i_in_data[4:0]};
                        w_next_state = (r_count == 14'd0) ? S_HEADER : S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    if (r_target == T_RF && r_rptr[5]) begin
                        w_next_state = S_ERROR;
                    end else begin
                        case (r_target)
                            T_IMEM:  w_imem_we = 1'b1;
                            T_DMEM:  w_dmem_we = 1'b1;
                            default: w_rf_we   = !(PROTECT_R0 && r_rptr[4:0] == 5'd0);
                        endcase
                        w_mptr  = r_mptr + ADDR_W'(1);
                        w_rptr  = r_rptr + 6'd1;
                        w_count = r_count - 14'd1;
                        if (r_count == 14'd1) begin
                            w_next_state = S_HEADER;
                        end
                    end
                end
            end
            default: w_next_state = r_state;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_HEADER;
            r_target     <= 2'b00;
            r_count      <= 14'd0;
            r_mptr       <= '0;
            r_rptr       <= 6'd0;
            o_in_ready   <= 1'b1;
            o_imem_we    <= 1'b0;
            o_imem_addr  <= '0;
            o_imem_wdata <= 32'd0;
            o_dmem_we    <= 1'b0;
            o_dmem_addr  <= '0;
            o_dmem_wdata <= 32'd0;
            o_rf_we      <= 1'b0;
            o_rf_waddr   <= 5'd0;
            o_rf_wdata   <= 32'd0;
            o_core_reset <= 1'b1;
            o_error      <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_target     <= w_target;
            r_count      <= w_count;
            r_mptr       <= w_mptr;
            r_rptr       <= w_rptr;
            o_in_ready   <= (w_next_state == S_HEADER) || (w_next_state == S_ADDR) ||
                            (w_next_state == S_DATA);
            o_core_reset <= (w_next_state != S_DONE);
            o_error      <= (w_next_state == S_ERROR);
            o_imem_we    <= w_imem_we;
            o_dmem_we    <= w_dmem_we;
            o_rf_we      <= w_rf_we;
            if (w_imem_we) begin
                o_imem_addr  <= r_mptr;
                o_imem_wdata <= i_in_data;
            end
            if (w_dmem_we) begin
                o_dmem_addr  <= r_mptr;
                o_dmem_wdata <= i_in_data;
            end
            if (w_rf_we) begin
                o_rf_waddr <= r_rptr[4:0];
                o_rf_wdata <= i_in_data;
            end
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - randomized self-checking bench for boot_loader
// Expected writes come from a record-level parse of each stream.
module tb_boot_loader;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_in_valid = 1'b0;
    logic [31:0] i_in_data = 32'd0;
    logic        o_in_ready;
    logic        o_imem_we;
    logic [29:0] o_imem_addr;
    logic [31:0] o_imem_wdata;
    logic        o_dmem_we;
    logic [29:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic        o_rf_we;
    logic [4:0]  o_rf_waddr;
    logic [31:0] o_rf_wdata;
    logic        o_core_reset;
    logic        o_error;

    boot_loader dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_in_valid(i_in_valid), .i_in_data(i_in_data),
        .o_in_ready(o_in_ready),
        .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr), .o_imem_wdata(o_imem_wdata),
        .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata),
        .o_rf_we(o_rf_we), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata),
        .o_core_reset(o_core_reset), .o_error(o_error)
    );

    always #5 i_clk = ~i_clk;

    typedef logic [31:0] word_q_t[$];
    typedef struct packed {
        logic        rdy;
        logic [2:0]  we;    // {rf, dmem, imem}
        logic [29:0] addr;
        logic [31:0] data;
    } beat_t;

    int    checks = 0;
    int    errors = 0;
    beat_t m_exp[$];
    beat_t m_obs[$];
    int    m_idle;
    bit    m_done, m_err;

    task automatic do_reset();
        i_reset    = 1'b1;
        i_in_valid = 1'b0;
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    // Parse the stream record by record and list what each beat should cause.
    task automatic model_stream(input word_q_t b);
        int n, i, stop_at, r, cnt;
        logic [31:0] h, a;
        logic [1:0]  tgt;
        bit bad;
        beat_t e;
        n = b.size();
        m_exp.delete();
        m_done = 0;
        m_err  = 0;
        for (int j = 0; j < n; j++) m_exp.push_back({1'b1, 3'b000, 30'd0, 32'd0});
        i = 0;
        stop_at = n;
        while (i < n) begin
            h = b[i];
            tgt = h[31:30];
            if (tgt == 2'b11) begin m_done = 1; stop_at = i + 1; break; end
            if (h[15:0] != 16'd0) begin m_err = 1; stop_at = i + 1; break; end
            if (i + 1 >= n) break;
            a = b[i+1];
            if (tgt != 2'b10 && a[1:0] != 2'b00) begin m_err = 1; stop_at = i + 2; break; end
            cnt = int'(h[29:16]);
            i = i + 2;
            bad = 0;
            for (int k = 0; k < cnt && i < n; k++) begin
                e = m_exp[i];
                if (tgt == 2'b10) begin
                    r = int'(a[4:0]) + k;
                    if (r > 31) begin bad = 1; break; end
                    if (r != 0) begin e.we = 3'b100; e.addr = 30'(r); e.data = b[i]; end
                end else begin
                    e.we   = (tgt == 2'b00) ? 3'b001 : 3'b010;
                    e.addr = a[31:2] + 30'(k);
                    e.data = b[i];
                end
                m_exp[i] = e;
                i++;
            end
            if (bad) begin m_err = 1; stop_at = i + 1; break; end
        end
        for (int j = stop_at; j < n; j++) m_exp[j].rdy = 1'b0;
    endtask

    // Drive each beat for one cycle, record what the DUT showed the cycle after,
    // then idle 0..maxgap cycles with noise on the data bus.
    task automatic play(input word_q_t b, input int maxgap);
        beat_t ob;
        int gap;
        m_obs.delete();
        m_idle = 0;
        foreach (b[k]) begin
            i_in_valid = 1'b1;
            i_in_data  = b[k];
            ob.rdy = o_in_ready;
            @(posedge i_clk);
            @(negedge i_clk);
            ob.we   = {o_rf_we, o_dmem_we, o_imem_we};
            ob.addr = o_imem_we ? o_imem_addr : o_dmem_we ? o_dmem_addr :
                      o_rf_we ? {25'd0, o_rf_waddr} : 30'd0;
            ob.data = o_imem_we ? o_imem_wdata : o_dmem_we ? o_dmem_wdata :
                      o_rf_we ? o_rf_wdata : 32'd0;
            m_obs.push_back(ob);
            i_in_valid = 1'b0;
            i_in_data  = $urandom;
            gap = (maxgap > 0) ? $urandom_range(maxgap, 0) : 0;
            repeat (gap) begin
                @(negedge i_clk);
                if (o_imem_we || o_dmem_we || o_rf_we) m_idle++;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({o_in_ready, o_imem_we, o_dmem_we, o_rf_we, o_core_reset, o_error} !== 6'b100010) begin
            errors++;
            $display("FAIL reset_flags got %b expected 100010",
                     {o_in_ready, o_imem_we, o_dmem_we, o_rf_we, o_core_reset, o_error});
        end
        checks++;
        if ({o_imem_addr, o_imem_wdata, o_dmem_addr, o_dmem_wdata, o_rf_waddr, o_rf_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_buses got nonzero address/data outputs, expected all zero");
        end
    endtask

    task automatic test_imem_load();
        word_q_t s;
        do_reset();
        s = '{32'h00020000, 32'h00400000, 32'h20020005, 32'h00000000};
        model_stream(s);
        play(s, 0);
        for (int k = 0; k < m_exp.size(); k++) begin
            checks++;
            if (m_obs[k] !== m_exp[k]) begin
                errors++;
                $display("FAIL imem_load beat %0d got rdy=%b we=%b addr=%h data=%h expected rdy=%b we=%b addr=%h data=%h",
                         k, m_obs[k].rdy, m_obs[k].we, m_obs[k].addr, m_obs[k].data,
                         m_exp[k].rdy, m_exp[k].we, m_exp[k].addr, m_exp[k].data);
            end
        end
        checks++;
        if (m_obs[2].addr !== 30'h00100000 || m_obs[3].addr !== 30'h00100001) begin
            errors++;
            $display("FAIL imem_load_addr got %h %h expected 00100000 00100001", m_obs[2].addr, m_obs[3].addr);
        end
        checks++;
        if (o_core_reset !== 1'b1) begin
            errors++;
            $display("FAIL imem_load_core_reset got %b expected 1", o_core_reset);
        end
    endtask

    task automatic test_rf_end();
        word_q_t s;
        do_reset();
        s = '{32'h80010000, 32'h00000002, 32'h00400021, 32'hC0000000};
        model_stream(s);
        play(s, 0);
        for (int k = 0; k < m_exp.size(); k++) begin
            checks++;
            if (m_obs[k] !== m_exp[k]) begin
                errors++;
                $display("FAIL rf_end beat %0d got we=%b addr=%h data=%h expected we=%b addr=%h data=%h",
                         k, m_obs[k].we, m_obs[k].addr, m_obs[k].data, m_exp[k].we, m_exp[k].addr, m_exp[k].data);
            end
        end
        checks++;
        if ({o_core_reset, o_in_ready, o_error} !== 3'b000) begin
            errors++;
            $display("FAIL rf_end_flags got core_reset/in_ready/error=%b expected 000",
                     {o_core_reset, o_in_ready, o_error});
        end
    endtask

    task automatic test_misaligned_dmem();
        word_q_t s;
        do_reset();
        s = '{32'h40010000, 32'h10000002};
        model_stream(s);
        play(s, 0);
        for (int k = 0; k < m_exp.size(); k++) begin
            checks++;
            if (m_obs[k] !== m_exp[k]) begin
                errors++;
                $display("FAIL misaligned beat %0d got we=%b expected we=%b", k, m_obs[k].we, m_exp[k].we);
            end
        end
        checks++;
        if ({o_error, o_in_ready, o_core_reset} !== 3'b101) begin
            errors++;
            $display("FAIL misaligned_flags got error/in_ready/core_reset=%b expected 101",
                     {o_error, o_in_ready, o_core_reset});
        end
    endtask

    task automatic test_rf_bounds();
        word_q_t s;
        logic [31:0] a, b;
        do_reset();
        a = $urandom;
        b = $urandom;
        s = '{32'h80030000, 32'h0000001F, a, b};
        model_stream(s);
        play(s, 0);
        for (int k = 0; k < m_exp.size(); k++) begin
            checks++;
            if (m_obs[k] !== m_exp[k]) begin
                errors++;
                $display("FAIL rf_bounds beat %0d got we=%b addr=%h data=%h expected we=%b addr=%h data=%h",
                         k, m_obs[k].we, m_obs[k].addr, m_obs[k].data, m_exp[k].we, m_exp[k].addr, m_exp[k].data);
            end
        end
        checks++;
        if (o_error !== 1'b1) begin
            errors++;
            $display("FAIL rf_bounds_error got %b expected 1", o_error);
        end
        do_reset();
        s = '{32'h80020000, 32'h00000000, a, b};
        model_stream(s);
        play(s, 0);
        for (int k = 0; k < m_exp.size(); k++) begin
            checks++;
            if (m_obs[k] !== m_exp[k]) begin
                errors++;
                $display("FAIL rf_r0 beat %0d got we=%b addr=%h data=%h expected we=%b addr=%h data=%h",
                         k, m_obs[k].we, m_obs[k].addr, m_obs[k].data, m_exp[k].we, m_exp[k].addr, m_exp[k].data);
            end
        end
        checks++;
        if (m_obs[2].we !== 3'b000 || o_error !== 1'b0) begin
            errors++;
            $display("FAIL rf_r0_drop got we=%b error=%b expected 000 0", m_obs[2].we, o_error);
        end
    endtask

    task automatic test_backpressure();
        word_q_t s;
        int pulses;
        do_reset();
        s = '{32'h40000000, 32'h10010000, 32'h40030000, {$urandom} & 32'hFFFFFFFC, $urandom, $urandom, $urandom};
        model_stream(s);
        play(s, 3);
        for (int k = 0; k < m_exp.size(); k++) begin
            checks++;
            if (m_obs[k] !== m_exp[k]) begin
                errors++;
                $display("FAIL backpressure beat %0d got we=%b addr=%h data=%h expected we=%b addr=%h data=%h",
                         k, m_obs[k].we, m_obs[k].addr, m_obs[k].data, m_exp[k].we, m_exp[k].addr, m_exp[k].data);
            end
        end
        pulses = 0;
        foreach (m_obs[k]) if (m_obs[k].we == 3'b010) pulses++;
        checks++;
        if (pulses != 3 || m_idle != 0) begin
            errors++;
            $display("FAIL backpressure_pulses got %0d dmem pulses, %0d idle strobes expected 3, 0", pulses, m_idle);
        end
    endtask

    task automatic test_random();
        word_q_t s;
        logic [1:0]  tgt;
        logic [13:0] cnt;
        logic [31:0] a;
        for (int it = 0; it < 25; it++) begin
            do_reset();
            s.delete();
            for (int rec = 0; rec < 4; rec++) begin
                tgt = 2'($urandom_range(2, 0));
                cnt = 14'($urandom_range(5, 0));
                s.push_back({tgt, cnt, ($urandom_range(15, 0) == 0) ? 16'h0100 : 16'h0000});
                if (tgt == 2'b10) a = 32'($urandom_range(31, 26));
                else a = {$urandom} & (($urandom_range(7, 0) == 0) ? 32'hFFFFFFFF : 32'hFFFFFFFC);
                s.push_back(a);
                for (int d = 0; d < int'(cnt); d++) s.push_back($urandom);
            end
            if ($urandom_range(1, 0) == 1) s.push_back(32'hC0000000 | ($urandom & 32'h3FFFFFFF));
            s.push_back($urandom);
            model_stream(s);
            play(s, 2);
            for (int k = 0; k < m_exp.size(); k++) begin
                checks++;
                if (m_obs[k] !== m_exp[k]) begin
                    errors++;
                    $display("FAIL random it %0d beat %0d got rdy=%b we=%b addr=%h data=%h expected rdy=%b we=%b addr=%h data=%h",
                             it, k, m_obs[k].rdy, m_obs[k].we, m_obs[k].addr, m_obs[k].data,
                             m_exp[k].rdy, m_exp[k].we, m_exp[k].addr, m_exp[k].data);
                end
            end
            checks++;
            if ({o_error, o_core_reset, m_idle} !== {m_err, !m_done, 32'd0}) begin
                errors++;
                $display("FAIL random_final it %0d got error=%b core_reset=%b idle=%0d expected %b %b 0",
                         it, o_error, o_core_reset, m_idle, m_err, !m_done);
            end
        end
    endtask

    task automatic test_reset_mid_data();
        word_q_t s;
        do_reset();
        s = '{32'h00040000, 32'h00000040};
        play(s, 0);
        i_in_valid = 1'b1;
        i_in_data  = 32'hDEADBEEF;
        @(posedge i_clk);
        #1;
        i_reset    = 1'b1;
        i_in_valid = 1'b0;
        @(negedge i_clk);
        checks++;
        if ({o_imem_we, o_in_ready, o_core_reset} !== 3'b011) begin
            errors++;
            $display("FAIL reset_mid_pending got imem_we/in_ready/core_reset=%b expected 011",
                     {o_imem_we, o_in_ready, o_core_reset});
        end
        @(negedge i_clk);
        i_reset = 1'b0;
        s = '{32'h00010000, 32'h00000100, 32'hCAFEF00D};
        model_stream(s);
        play(s, 1);
        for (int k = 0; k < m_exp.size(); k++) begin
            checks++;
            if (m_obs[k] !== m_exp[k]) begin
                errors++;
                $display("FAIL reset_mid_after beat %0d got we=%b addr=%h data=%h expected we=%b addr=%h data=%h",
                         k, m_obs[k].we, m_obs[k].addr, m_obs[k].data, m_exp[k].we, m_exp[k].addr, m_exp[k].data);
            end
        end
        checks++;
        if (o_core_reset !== 1'b1 || m_idle != 0) begin
            errors++;
            $display("FAIL reset_mid_core_reset got %b idle=%0d expected 1 0", o_core_reset, m_idle);
        end
    endtask

    initial begin
        test_reset();
        test_imem_load();
        test_rf_end();
        test_misaligned_dmem();
        test_rf_bounds();
        test_backpressure();
        test_random();
        test_reset_mid_data();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
# boot_loader

Stream-driven preload engine for the single-cycle MIPS `machine`. It accepts a word stream over a valid/ready handshake and writes the payload into instruction memory, data memory and the register file through dedicated write ports. It holds the core in reset until an END record arrives. It takes over the register and memory preloads that benches currently perform by hierarchical assignment, and is the write-side counterpart of the end-of-run register and memory dump.

## Interface
- `ADDR_W`, default 30: width of the word address driven to the memories; byte address bits [31:2].
- `PROTECT_R0`, default 1: when 1, register-file writes to r0 are dropped silently and do not raise an error.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; returns the block to HEADER immediately.
- `in_valid`  in  1  stream word present.
- `in_data`  in  32  stream word.
- `in_ready`  out  1  block accepts `in_data` this cycle.
- `imem_we`  out  1  instruction-memory write strobe.
- `imem_addr`  out  ADDR_W  instruction-memory word address.
- `imem_wdata`  out  32  instruction-memory write data.
- `dmem_we`  out  1  data-memory write strobe.
- `dmem_addr`  out  ADDR_W  data-memory word address.
- `dmem_wdata`  out  32  data-memory write data.
- `rf_we`  out  1  register-file write strobe.
- `rf_waddr`  out  5  register number.
- `rf_wdata`  out  32  register write data.
- `core_reset`  out  1  reset to `machine`; high until END is accepted.
- `error`  out  1  sticky protocol error.

## Operation
- A beat is accepted when `in_valid && in_ready` at a rising edge. No other cycle has an effect.
- The stream is a sequence of records: a header word, then an address word, then COUNT data words.
- Header format:
  - [31:30] target: 00 imem, 01 dmem, 10 regfile, 11 END.
  - [29:16] COUNT, 0..16383.
  - [15:0] must be zero.
- States:
  - HEADER: next beat is decoded as a header. Target 11 goes to DONE; nonzero [15:0] goes to ERROR; any other header goes to ADDR.
  - ADDR: for imem/dmem, byte address with [1:0] != 0 goes to ERROR. Otherwise the start pointer is loaded: address [31:2] for memories, [4:0] for regfile. COUNT = 0 returns to HEADER, else goes to DATA.
  - DATA: each beat issues one write to the current pointer, then increments the pointer. After the COUNT-th beat, return to HEADER.
  - DONE: `in_ready` = 0 and `core_reset` = 0. The block stays here until `reset`.
  - ERROR: `in_ready` = 0, `error` = 1 and `core_reset` = 1. The block stays here until `reset`.
- Pointer arithmetic:
  - The memory pointer is ADDR_W bits and wraps modulo 2^ADDR_W.
  - The register pointer does not wrap. A data beat with the pointer past r31 is not written and the block goes to ERROR.
- When PROTECT_R0 = 1, a regfile beat targeting r0 produces no `rf_we`. The pointer still advances to r1.
- In END, COUNT is ignored and no address word follows.

## Timing
- Reset values: state HEADER, `in_ready` = 1, every `*_we` = 0, all address and data outputs = 0, `core_reset` = 1, `error` = 0.
- `in_ready` is a registered function of state only and does not depend on `in_valid`. It is 1 in HEADER, ADDR and DATA.
- Write latency is one cycle. The strobe, address and data are registered and held for exactly the cycle after the accepting edge. Only one `*_we` is high in any cycle.
- Back-to-back writes are possible, one per cycle, at full throughput. Idle gaps in `in_valid` produce no strobes.
- `core_reset` falls on the edge that accepts the END header and is low from the following cycle.
- `error` rises on the edge that accepts the offending beat. The offending beat produces no write.
- Reset asserted mid-record:
  - outputs return to reset values asynchronously;
  - any registered write pending for the next cycle is discarded;
  - the partially received record is abandoned.

## Test plan
- Imem load: headers and data 0x00020000, 0x00400000, 0x20020005, 0x00000000 -> two `imem_we` pulses on consecutive cycles at word addresses 0x00100000 and 0x00100001 with those data; `core_reset` stays 1.
- RF preload, then END: 0x80010000, 0x00000002, 0x00400021, then 0xC0000000 -> one `rf_we` with `rf_waddr` = 2 and `rf_wdata` = 0x00400021. `core_reset` is 0 from the cycle after END is accepted, and `in_ready` is 0.
- Misaligned dmem: 0x40010000, 0x10000002 -> `error` = 1 and `in_ready` = 0 from the next cycle; no `dmem_we`; `core_reset` stays 1.
- RF bounds and r0: 0x80030000, 0x0000001F, then data A, B -> r31 written with A, the second data beat raises `error`, and no write occurs. Separately, 0x80020000, 0x00000000, X, Y -> only r1 is written (with Y).
- Backpressure and empty record:
  - with 0–3 idle cycles randomly inserted between beats, 0x40000000, 0x10010000 (COUNT 0) produces no strobe and returns to HEADER;
  - a subsequent dmem record with COUNT 3 produces exactly 3 `dmem_we` pulses, each one cycle after its accepting edge.
- Reset mid-DATA: assert `reset` after 1 of 4 imem data beats, coincident with a pending write -> the pending write never appears. After release the block accepts a new header and `core_reset` = 1 throughout.
